exe_mem_req: RTL
================

// Module: exe_mem_req
// PURPOSE
//  EXE-stage memory request generator for the sram-like (req/addr_ok/data_ok) data bus, replacing the
//  single-cycle data_sram_en/wen port. Issues load/store requests, computes byte strobes and ALE, and
//  tracks outstanding requests. Requests orphaned by a WB flush are marked so MEM discards their data_ok.
//  Sits between exe_stage's ALU result and the data bus; drives exe_stage's ready_go for memory ops.
// PARAMETERS
//  ADDR_W           32  byte-address width
//  MAX_OUTSTANDING  2   max requests accepted (addr_ok) but not yet answered (data_ok); >=1
//  CNT_W = $clog2(MAX_OUTSTANDING+1)  derived width of outstanding/discard counters; not overridable
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  es_valid     in   1       EXE stage holds a valid instruction
//  es_mem_op    in   1       instruction is load or store
//  es_is_store  in   1       1 = store, 0 = load
//  es_size      in   2       `MEM_SIZE_B/H/W (0/1/2)
//  es_vaddr     in   ADDR_W  ALU-computed byte address
//  es_rkd_value in   32      raw store data
//  es_advance   in   1       EXE->MEM handoff this cycle (es_to_ms_valid & ms_allowin)
//  flush        in   1       wb_exc | wb_ertn | ms_to_es_st_cancel
//  req          out  1       bus request
//  wr           out  1       1 = write
//  size         out  2       = es_size
//  wstrb        out  4       byte enables (0 for loads)
//  addr         out  ADDR_W  unaligned byte address = es_vaddr
//  wdata        out  32      replicated store data
//  addr_ok      in   1       request accepted this cycle
//  data_ok      in   1       response this cycle (in order)
//  resp_drop    out  1       current data_ok belongs to a flushed request; MEM ignores it
//  mem_ready_go out  1       memory part of EXE done
//  ale          out  1       misaligned access exception flag
// BEHAVIOUR
//  - reset: state IDLE, req=0, outstanding=0, discard=0; all outputs 0 except mem_ready_go=1.
//  - ale = es_valid & es_mem_op & (H & vaddr[0] | W & |vaddr[1:0]); combinational.
//  - wstrb: B -> 4'h1<<vaddr[1:0]; H -> 4'h3<<{vaddr[1],1'b0}; W -> 4'hf; loads -> 4'h0.
//  - wdata: B -> {4{rkd[7:0]}}; H -> {2{rkd[15:0]}}; W -> rkd.
//  - FSM IDLE/REQ/DONE/ORPHAN:
//    IDLE: start = es_valid & es_mem_op & ~ale & ~flush & outstanding<MAX_OUTSTANDING.
//          start -> REQ (req asserted same cycle, combinationally); addr_ok same cycle -> DONE.
//    REQ:  req=1, addr/wr/size/wstrb/wdata held stable until addr_ok. addr_ok -> DONE;
//          flush while REQ (no addr_ok) -> ORPHAN; flush & addr_ok same cycle -> IDLE, discard++.
//    ORPHAN: req=1 (request never withdrawn); on addr_ok -> IDLE, discard++.
//    DONE: mem_ready_go=1; es_advance -> IDLE; flush before advance -> IDLE, discard++.
//  - mem_ready_go = ~es_mem_op | ale | flush | state==DONE | (IDLE|REQ with addr_ok this cycle).
//    ALE or flushed op never issues a request.
//  - outstanding: +1 on addr_ok, -1 on data_ok, both -> unchanged. Never exceeds MAX_OUTSTANDING;
//    at MAX, IDLE stalls (mem_ready_go=0) until a data_ok frees a slot.
//  - discard: +1 per orphaned accepted request. resp_drop = data_ok & discard!=0; decrement on it.
//    Increment and drop-decrement same cycle -> unchanged.
//  - data_ok with outstanding==0: illegal, assertion fires.
//  - reset mid-transaction returns to IDLE and clears both counters; bus must also be reset.
// STRUCTURE
//  - mycpu.h: `MEM_SIZE_B/H/W, state encodings `EMR_IDLE/REQ/DONE/ORPHAN.
//  - One sub-module: emr_req_counter (CNT_W up/down counter with simultaneous inc/dec),
//    instantiated twice (outstanding, discard).
// TESTING
//  1 sw vaddr=0x1004, rkd=0x11223344, addr_ok same cycle -> req=1,wr=1,wstrb=f,wdata=0x11223344, ready_go same cycle.
//  2 st.b vaddr=0x1003, rkd=0xAB, addr_ok after 3 cycles -> wstrb=8, wdata=0xABABABAB, req/addr stable 3 cycles.
//  3 ld.w vaddr=0x1002 -> ale=1, req never asserted, mem_ready_go=1.
//  4 ld.w in REQ, flush cycle 2, addr_ok cycle 4 -> req held to cycle 4; next data_ok has resp_drop=1, discard back to 0.
//  5 MAX_OUTSTANDING=2, 3 loads, no data_ok -> third stalls, mem_ready_go=0; data_ok -> third issues.
//  6 addr_ok and data_ok same cycle with outstanding=1 -> outstanding stays 1.

Source files
------------

// File: rtl/exe_mem_req_pkg.sv
// Shared types and helpers for the EXE-stage memory request generator.
// This package takes the place of the mycpu.h size codes and state encodings.
package exe_mem_req_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    EMR_IDLE   = 2'd0,
    EMR_REQ    = 2'd1,
    EMR_DONE   = 2'd2,
    EMR_ORPHAN = 2'd3
  } emr_state_e;

  // Request payload captured at issue and held until the bus accepts it.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } emr_req_t;

  function automatic logic [3:0] emr_wstrb(input logic is_store, input logic [1:0] size,
                                           input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      MEM_SIZE_B: s = 4'b0001 << lo;
      MEM_SIZE_H: s = 4'b0011 << {lo[1], 1'b0};
      MEM_SIZE_W: s = 4'hf;
      default:    s = 4'h0;
    endcase
    return is_store ? s : 4'h0;
  endfunction

  function automatic logic [31:0] emr_wdata(input logic [1:0] size, input logic [31:0] rkd);
    case (size)
      MEM_SIZE_B: return {4{rkd[7:0]}};
      MEM_SIZE_H: return {2{rkd[15:0]}};
      default:    return rkd;
    endcase
  endfunction

endpackage

// File: rtl/exe_mem_req_counter.sv
// Small up/down counter for in-flight request bookkeeping.
// An increment and a decrement in the same cycle cancel out.
module emr_req_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage request generator for the req/addr_ok/data_ok data bus: issues loads and stores,
// keeps a flushed request on the bus until it is accepted, and tags its response for MEM to drop.
module exe_mem_req
  import exe_mem_req_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_valid_i,
  input  logic              es_mem_op_i,
  input  logic              es_is_store_i,
  input  logic [1:0]        es_size_i,
  input  logic [ADDR_W-1:0] es_vaddr_i,
  input  logic [31:0]       es_rkd_value_i,
  input  logic              es_advance_i,
  input  logic              flush_i,
  output logic              req_o,
  output logic              wr_o,
  output logic [1:0]        size_o,
  output logic [3:0]        wstrb_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic              addr_ok_i,
  input  logic              data_ok_i,
  output logic              resp_drop_o,
  output logic              mem_ready_go_o,
  output logic              ale_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  emr_state_e        state_q, state_d;
  emr_req_t          req_q, req_d, cur, pay;
  logic [ADDR_W-1:0] addr_q, addr_d, pay_addr;
  logic [CNT_W-1:0]  out_cnt, disc_cnt;
  logic              has_slot, start, accept, disc_inc;

  assign ale_o = es_valid_i & es_mem_op_i &
                 ((es_size_i == MEM_SIZE_H & es_vaddr_i[0]) |
                  (es_size_i == MEM_SIZE_W & |es_vaddr_i[1:0]));

  assign cur = '{wr:    es_is_store_i,
                 size:  es_size_i,
                 wstrb: emr_wstrb(es_is_store_i, es_size_i, es_vaddr_i[1:0]),
                 wdata: emr_wdata(es_size_i, es_rkd_value_i)};

  assign has_slot = out_cnt < CNT_W'(MAX_OUTSTANDING);
  assign start    = es_valid_i & es_mem_op_i & ~ale_o & ~flush_i & has_slot;
  assign accept   = req_o & addr_ok_i;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    req_o    = 1'b0;
    disc_inc = 1'b0;
    case (state_q)
      EMR_IDLE: if (start) begin
        req_o   = 1'b1;
        req_d   = cur;
        addr_d  = es_vaddr_i;
        state_d = addr_ok_i ? EMR_DONE : EMR_REQ;
      end
      EMR_REQ: begin
        req_o = 1'b1;
        if (addr_ok_i && flush_i) begin
          state_d  = EMR_IDLE;
          disc_inc = 1'b1;
        end else if (addr_ok_i) state_d = EMR_DONE;
        else if (flush_i)       state_d = EMR_ORPHAN;
      end
      // The bus protocol forbids withdrawing a request, so a flushed one rides out to addr_ok.
      EMR_ORPHAN: begin
        req_o = 1'b1;
        if (addr_ok_i) begin
          state_d  = EMR_IDLE;
          disc_inc = 1'b1;
        end
      end
      EMR_DONE: begin
        if (es_advance_i) state_d = EMR_IDLE;
        else if (flush_i) begin
          state_d  = EMR_IDLE;
          disc_inc = 1'b1;
        end
      end
      default: state_d = EMR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMR_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // In IDLE the request goes out straight from EXE; afterwards from the captured copy.
  assign pay      = (state_q == EMR_IDLE) ? cur : req_q;
  assign pay_addr = (state_q == EMR_IDLE) ? es_vaddr_i : addr_q;
  assign wr_o     = req_o & pay.wr;
  assign size_o   = req_o ? pay.size  : 2'b0;
  assign wstrb_o  = req_o ? pay.wstrb : 4'b0;
  assign wdata_o  = req_o ? pay.wdata : 32'b0;
  assign addr_o   = req_o ? pay_addr  : '0;

  assign mem_ready_go_o = ~es_mem_op_i | ale_o | flush_i | (state_q == EMR_DONE) |
                          (((state_q == EMR_IDLE) | (state_q == EMR_REQ)) & accept);

  assign resp_drop_o = data_ok_i & (disc_cnt != '0);

  emr_req_counter #(.CNT_W(CNT_W)) u_outstanding (
    .clk  (clk),
    .reset(reset),
    .inc_i(accept),
    .dec_i(data_ok_i),
    .cnt_o(out_cnt)
  );

  emr_req_counter #(.CNT_W(CNT_W)) u_discard (
    .clk  (clk),
    .reset(reset),
    .inc_i(disc_inc),
    .dec_i(resp_drop_o),
    .cnt_o(disc_cnt)
  );

  a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (reset)
    data_ok_i |-> out_cnt != '0);

endmodule
